result_argmax: RTL and testbench
================================

# result_argmax

Parametrised classification-result stage at the tail of the network. When enabled, it streams NUM_CLASSES signed scores from the output-layer memory starting at memstartp and tracks the best and runner-up scores. It then reports the winning class as an index, as an active-low seven-segment code, and as a confidence margin. It replaces the fixed 10-class, fixed-latency result stage and removes its zero-initialised maximum, so all-negative score vectors are handled correctly.

## Interface
- SIZE_1, 11: score width (signed two's complement)
- SIZE_address_pix, 13: memory address width
- NUM_CLASSES, 10: number of scores read, 1..16
- RD_LATENCY, 2: cycles from read_addressp/re edge to the qp sample edge, 1..4
- TIE_LAST, 1: 1 = a later equal score wins (>=); 0 = an earlier equal score wins (>)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level run request; deassertion aborts and clears STOP
- memstartp  in  SIZE_address_pix  base address of score vector, sampled at start
- qp  in  SIZE_1  read data, signed
- re  out  1  memory read enable
- read_addressp  out  SIZE_address_pix  memory read address
- STOP  out  1  result valid / done, held until enable falls
- RESULT  out  8  seven-segment code of winner, active-low segments
- class_idx  out  4  winning class index
- second_idx  out  4  runner-up class index
- margin  out  SIZE_1+1  best minus runner-up, always >= 0

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE, enable=1:
  - latch base = memstartp
  - read_addressp <= memstartp, re <= 1, issue counter = 1
  - go to READ, or to DRAIN if NUM_CLASSES=1
- READ: read_addressp <= base + issue counter, one per cycle; leave for DRAIN after address NUM_CLASSES-1 is issued.
- DRAIN: hold the last address and re=1 until all samples are taken, then go to DONE.
- Sample pipeline: a RD_LATENCY-deep valid/index shift register tags each issued address; qp is captured at the edge where the tag emerges.
- Compare (signed, full SIZE_1):
  - sample 0 initialises best = qp, best index 0, second invalid.
  - Later samples use the tie rule given by TIE_LAST (>= or >).
  - If the sample beats best: second <= best, best <= sample.
  - Else, if second is invalid or the sample beats second: second <= sample.
- DONE (one-cycle entry actions):
  - class_idx and second_idx registered
  - margin = best - second, sign-extended to SIZE_1+1; margin = 0 and second_idx = 0 when NUM_CLASSES=1
  - RESULT registered, STOP <= 1, re <= 0
  - stay in DONE while enable=1
- Seven-segment map (index: code): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, 10 88, 11 83, 12 C6, 13 A1, 14 86, 15 8E.
- enable=0 in any state: next edge goes to IDLE, STOP=0, re=0, pipeline flushed. class_idx, second_idx, margin and RESULT keep the last completed result; an aborted run never updates them.
- Restart needs enable low for at least one edge; memstartp changes mid-run are ignored.

## Timing
- Reset values: STOP=0, re=0, read_addressp=0, RESULT=8'hFF, class_idx=0, second_idx=0, margin=0, FSM in IDLE.
- Edge c0 is the first edge with enable=1 in IDLE.
  - Address k is driven at edge c0+k.
  - qp for address k is sampled at edge c0+k+RD_LATENCY.
  - Results and STOP=1 appear at edge c0+NUM_CLASSES+RD_LATENCY (defaults: 12 edges after c0).
- re is high from c0 through edge c0+NUM_CLASSES+RD_LATENCY-1.
- Reset mid-run: immediate return to reset values, independent of clk.

## Test plan
- Defaults, base 100, scores [3,-5,7,2,7,1,0,-1,4,6], TIE_LAST=1:
  - class_idx=4, RESULT=99, second_idx=2, margin=0
  - STOP rises 12 edges after c0; addresses 100..109 each seen once
- Same vector with TIE_LAST=0 -> class_idx=2, RESULT=A4, second_idx=4, margin=0.
- All-negative scores [-9,-3,-7,-4,-8,-6,-5,-10,-11,-12] -> class_idx=1, RESULT=F9, second_idx=3, margin=1.
- NUM_CLASSES=16, RD_LATENCY=1, peak 500 at index 13, runner-up 200 at index 5:
  - class_idx=13, RESULT=A1, second_idx=5, margin=300
  - STOP at edge c0+17
- Drop enable at edge c0+5, then rerun with base 200:
  - STOP never rises during the aborted run; outputs keep the previous result
  - the rerun reads 200..209 and reports fresh values
- Assert rst_n low mid-DRAIN -> outputs immediately take reset values (RESULT=FF, STOP=0, re=0); a clean run after release gives the correct result.

Source files
------------

// File: rtl/result_argmax.sv
// rtl/result_argmax.sv - streams NUM_CLASSES signed scores from memory and reports best class,
// runner-up class, confidence margin and an active-low seven-segment code.
module result_argmax #(
    parameter int SIZE_1           = 11,
    parameter int SIZE_address_pix = 13,
    parameter int NUM_CLASSES      = 10,
    parameter int RD_LATENCY       = 2,
    parameter bit TIE_LAST         = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [SIZE_address_pix-1:0] memstartp,
    input  logic signed [SIZE_1-1:0]    qp,
    output logic                        re,
    output logic [SIZE_address_pix-1:0] read_addressp,
    output logic                        STOP,
    output logic [7:0]                  RESULT,
    output logic [3:0]                  class_idx,
    output logic [3:0]                  second_idx,
    output logic [SIZE_1:0]             margin
);

    localparam int CNTW = 5;
    localparam logic [CNTW-1:0] LAST_ISSUE  = CNTW'(NUM_CLASSES - 1);
    localparam logic [CNTW-1:0] ALL_SAMPLES = CNTW'(NUM_CLASSES);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [SIZE_address_pix-1:0] base;
    logic [CNTW-1:0]             issue_cnt;
    logic [CNTW-1:0]             samp_cnt;
    logic                        pipe_v   [RD_LATENCY];
    logic [3:0]                  pipe_idx [RD_LATENCY];

    logic signed [SIZE_1-1:0]    best;
    logic signed [SIZE_1-1:0]    second;
    logic [3:0]                  best_idx;
    logic [3:0]                  second_idx_r;
    logic                        second_v;

    logic                        issue_v;
    logic [3:0]                  issue_idx;
    logic                        finish;
    logic                        take;
    logic [3:0]                  sample_idx;
    logic                        beats_best;
    logic                        beats_second;
    logic [SIZE_1:0]             diff;

    function automatic logic [7:0] seg7(input logic [3:0] idx);
        case (idx)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            4'd10:   seg7 = 8'h88;
            4'd11:   seg7 = 8'h83;
            4'd12:   seg7 = 8'hC6;
            4'd13:   seg7 = 8'hA1;
            4'd14:   seg7 = 8'h86;
            default: seg7 = 8'h8E;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue_v    = 1'b0;
        issue_idx  = '0;
        finish     = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    issue_v    = 1'b1;
                    state_next = (NUM_CLASSES == 1) ? DRAIN : READ;
                end
                READ: begin
                    issue_v   = 1'b1;
                    issue_idx = issue_cnt[3:0];
                    if (issue_cnt == LAST_ISSUE) state_next = DRAIN;
                end
                DRAIN: begin
                    if (samp_cnt == ALL_SAMPLES) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // The tag leaving the last pipeline stage marks the edge at which qp belongs to it.
    assign take         = enable && pipe_v[RD_LATENCY-1];
    assign sample_idx   = pipe_idx[RD_LATENCY-1];
    assign beats_best   = TIE_LAST ? (qp >= best)   : (qp > best);
    assign beats_second = TIE_LAST ? (qp >= second) : (qp > second);
    assign diff         = {best[SIZE_1-1], best} - {second[SIZE_1-1], second};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base          <= '0;
            issue_cnt     <= '0;
            samp_cnt      <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_idx[i] <= '0;
            end
            best          <= '0;
            second        <= '0;
            best_idx      <= '0;
            second_idx_r  <= '0;
            second_v      <= 1'b0;
            re            <= 1'b0;
            read_addressp <= '0;
            STOP          <= 1'b0;
            RESULT        <= 8'hFF;
            class_idx     <= '0;
            second_idx    <= '0;
            margin        <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            pipe_v[0]   <= issue_v;
            pipe_idx[0] <= issue_idx;

            if (take) begin
                samp_cnt <= samp_cnt + 1'b1;
                if (samp_cnt == '0) begin
                    best     <= qp;
                    best_idx <= sample_idx;
                    second_v <= 1'b0;
                end else if (beats_best) begin
                    second       <= best;
                    second_idx_r <= best_idx;
                    second_v     <= 1'b1;
                    best         <= qp;
                    best_idx     <= sample_idx;
                end else if (!second_v || beats_second) begin
                    second       <= qp;
                    second_idx_r <= sample_idx;
                    second_v     <= 1'b1;
                end
            end

            if (!enable) begin
                re   <= 1'b0;
                STOP <= 1'b0;
                for (int i = 0; i < RD_LATENCY; i++) pipe_v[i] <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        base          <= memstartp;
                        read_addressp <= memstartp;
                        re            <= 1'b1;
                        issue_cnt     <= CNTW'(1);
                        samp_cnt      <= '0;
                    end
                    READ: begin
                        read_addressp <= base + SIZE_address_pix'(issue_cnt);
                        issue_cnt     <= issue_cnt + 1'b1;
                    end
                    DRAIN: begin
                        if (finish) begin
                            class_idx <= best_idx;
                            RESULT    <= seg7(best_idx);
                            STOP      <= 1'b1;
                            re        <= 1'b0;
                            if (NUM_CLASSES == 1) begin
                                second_idx <= '0;
                                margin     <= '0;
                            end else begin
                                second_idx <= second_idx_r;
                                margin     <= diff;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_argmax.sv
// tb/tb_result_argmax.sv - scoreboard bench for result_argmax over three parameter sets.
module tb_result_argmax;

    logic clk;
    logic rst_n;
    logic [12:0] memstartp;
    logic en_a, en_b, en_c;
    logic signed [10:0] qp_a, qp_b, qp_c;
    logic re_a, re_b, re_c;
    logic [12:0] addr_a, addr_b, addr_c;
    logic stop_a, stop_b, stop_c;
    logic [7:0] res_a, res_b, res_c;
    logic [3:0] cls_a, cls_b, cls_c;
    logic [3:0] sec_a, sec_b, sec_c;
    logic [11:0] mar_a, mar_b, mar_c;

    logic signed [10:0] mem_ab [8192];
    logic signed [10:0] mem_c  [8192];

    typedef struct {
        logic [3:0]  cls;
        logic [3:0]  sec;
        logic [11:0] mar;
        logic [7:0]  res;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int sel = 0;

    logic        o_re, o_stop;
    logic [12:0] o_addr;
    logic [7:0]  o_res;
    logic [3:0]  o_cls, o_sec;
    logic [11:0] o_mar;

    result_argmax u_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .memstartp(memstartp), .qp(qp_a),
        .re(re_a), .read_addressp(addr_a), .STOP(stop_a), .RESULT(res_a),
        .class_idx(cls_a), .second_idx(sec_a), .margin(mar_a)
    );

    result_argmax #(.TIE_LAST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .memstartp(memstartp), .qp(qp_b),
        .re(re_b), .read_addressp(addr_b), .STOP(stop_b), .RESULT(res_b),
        .class_idx(cls_b), .second_idx(sec_b), .margin(mar_b)
    );

    result_argmax #(.NUM_CLASSES(16), .RD_LATENCY(1)) u_c (
        .clk(clk), .rst_n(rst_n), .enable(en_c), .memstartp(memstartp), .qp(qp_c),
        .re(re_c), .read_addressp(addr_c), .STOP(stop_c), .RESULT(res_c),
        .class_idx(cls_c), .second_idx(sec_c), .margin(mar_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle memories for u_a/u_b, combinational read for u_c.
    always @(posedge clk) begin
        qp_a <= mem_ab[addr_a];
        qp_b <= mem_ab[addr_b];
    end
    always_comb qp_c = mem_c[addr_c];

    always_comb begin
        o_re = re_a; o_stop = stop_a; o_addr = addr_a; o_res = res_a;
        o_cls = cls_a; o_sec = sec_a; o_mar = mar_a;
        if (sel == 1) begin
            o_re = re_b; o_stop = stop_b; o_addr = addr_b; o_res = res_b;
            o_cls = cls_b; o_sec = sec_b; o_mar = mar_b;
        end else if (sel == 2) begin
            o_re = re_c; o_stop = stop_c; o_addr = addr_c; o_res = res_c;
            o_cls = cls_c; o_sec = sec_c; o_mar = mar_c;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_en(input logic v);
        en_a = (sel == 0) && v;
        en_b = (sel == 1) && v;
        en_c = (sel == 2) && v;
    endtask

    task automatic chk_result(input string tag, input exp_t e);
        chk({tag, "_class_idx"}, o_cls, e.cls);
        chk({tag, "_second_idx"}, o_sec, e.sec);
        chk({tag, "_margin"}, o_mar, e.mar);
        chk({tag, "_RESULT"}, o_res, e.res);
    endtask

    task automatic run(input int s, input int n, input int lat, input logic [12:0] b, input exp_t e);
        exp_t got;
        sel = s;
        @(negedge clk);
        memstartp = b;
        set_en(1'b1);
        sb.push_back(e);
        for (int k = 0; k <= n + lat; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) memstartp = 13'h1FFF;
            if (k < n) chk("read_addressp", o_addr, b + 13'(k));
            chk("re", o_re, (k < n + lat));
            chk("STOP_timing", o_stop, (k == n + lat));
            if (o_stop) begin
                chk("sb_depth", sb.size(), 1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    chk_result("run", got);
                end
            end
        end
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        set_en(1'b0);
        @(posedge clk);
        #1;
        chk("STOP_after_disable", o_stop, 0);
        chk("re_after_disable", o_re, 0);
        chk_result("hold", e);
    endtask

    int v1[10]   = '{3, -5, 7, 2, 7, 1, 0, -1, 4, 6};
    int vneg[10] = '{-9, -3, -7, -4, -8, -6, -5, -10, -11, -12};
    int vext[10] = '{-1024, -1024, -1024, -1024, -1024, -1024, -1024, 1023, -1024, -1024};

    initial begin
        exp_t e;
        rst_n = 1'b1;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        memstartp = '0;
        for (int i = 0; i < 8192; i++) begin
            mem_ab[i] = '0;
            mem_c[i]  = '0;
        end
        for (int i = 0; i < 10; i++) begin
            mem_ab[100 + i] = 11'(v1[i]);
            mem_ab[300 + i] = 11'(vneg[i]);
            mem_ab[200 + i] = 11'(vext[i]);
        end
        for (int i = 0; i < 16; i++) mem_c[50 + i] = 11'(i * 7 - 40);
        mem_c[63] = 11'sd500;
        mem_c[55] = 11'sd200;

        #1 rst_n = 1'b0;
        #1;
        sel = 0;
        #0;
        chk("rst_STOP", stop_a, 0);
        chk("rst_re", re_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_RESULT", res_a, 8'hFF);
        chk("rst_class_idx", cls_a, 0);
        chk("rst_second_idx", sec_a, 0);
        chk("rst_margin", mar_a, 0);
        chk("rst_c_RESULT", res_c, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        e = '{cls: 4'd4, sec: 4'd2, mar: 12'd0, res: 8'h99};
        run(0, 10, 2, 13'd100, e);
        e = '{cls: 4'd2, sec: 4'd4, mar: 12'd0, res: 8'hA4};
        run(1, 10, 2, 13'd100, e);
        e = '{cls: 4'd1, sec: 4'd3, mar: 12'd1, res: 8'hF9};
        run(0, 10, 2, 13'd300, e);
        e = '{cls: 4'd13, sec: 4'd5, mar: 12'd300, res: 8'hA1};
        run(2, 16, 1, 13'd50, e);

        // Abort at edge c0+5: nothing may change, then a fresh run from base 200.
        sel = 0;
        @(negedge clk);
        memstartp = 13'd100;
        set_en(1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("abort_STOP_low", o_stop, 0);
        end
        @(negedge clk);
        set_en(1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("abort_STOP", o_stop, 0);
            chk("abort_re", o_re, 0);
        end
        e = '{cls: 4'd1, sec: 4'd3, mar: 12'd1, res: 8'hF9};
        chk_result("abort_hold", e);
        e = '{cls: 4'd7, sec: 4'd9, mar: 12'd2047, res: 8'hF8};
        run(0, 10, 2, 13'd200, e);

        // Reset asserted between clock edges while in DRAIN.
        sel = 0;
        @(negedge clk);
        memstartp = 13'd300;
        set_en(1'b1);
        repeat (11) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_RESULT", o_res, 8'hFF);
        chk("midrst_STOP", o_stop, 0);
        chk("midrst_re", o_re, 0);
        chk("midrst_addr", o_addr, 0);
        chk("midrst_class_idx", o_cls, 0);
        chk("midrst_margin", o_mar, 0);
        set_en(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        e = '{cls: 4'd1, sec: 4'd3, mar: 12'd1, res: 8'hF9};
        run(0, 10, 2, 13'd300, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
